alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU. It replaces the single-cycle add/sub unit in the datapath.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq. The requester uses the master modport and the ALU uses
// the slave modport.
interface alu_seq_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] alu_A_in;
    logic [DATA_WIDTH-1:0] alu_B_in;
    logic [2:0]            alu_op_in;
    logic                  alu_valid_in;
    logic                  alu_ready_out;
    logic                  alu_done_out;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_Z_out;
    logic                  alu_N_out;
    logic                  alu_C_out;
    logic                  alu_V_out;

    modport master (
        output alu_A_in, alu_B_in, alu_op_in, alu_valid_in,
        input  alu_ready_out, alu_done_out, alu_out, alu_Z_out, alu_N_out, alu_C_out, alu_V_out
    );

    modport slave (
        input  alu_A_in, alu_B_in, alu_op_in, alu_valid_in,
        output alu_ready_out, alu_done_out, alu_out, alu_Z_out, alu_N_out, alu_C_out, alu_V_out
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, bit-serial shifts and a shift-add multiply.
// Result and Z/N/C/V flags are registered and held until the next completion.
module alu_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          MUL_ENABLE = 1'b1
) (
    input logic       clock_in,
    input logic       reset_in,
    alu_seq_if.slave  bus
);
    localparam int unsigned W       = DATA_WIDTH;
    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W   = SHAMT_W + 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;

    typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               shl_q, shl_d;
    logic [2*W-1:0]     acc_q, acc_d;
    logic [W-1:0]       out_q, out_d;
    logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic               done_q;

    logic               wr;
    logic [W-1:0]       res;
    logic               c_f, v_f;

    logic [W:0]         add_sum, sub_diff, mul_add;
    logic [2*W-1:0]     acc_step;
    logic [W-1:0]       shift_next;
    logic               shift_bit;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;

    assign accept   = bus.alu_valid_in && (state_q == StIdle);
    assign shamt    = bus.alu_B_in[SHAMT_W-1:0];
    assign add_sum  = {1'b0, bus.alu_A_in} + {1'b0, bus.alu_B_in};
    assign sub_diff = {1'b0, bus.alu_A_in} - {1'b0, bus.alu_B_in};

    // Upper half accumulates; the multiplier sits in the low half and drains out to the right.
    assign mul_add  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign acc_step = {mul_add, acc_q[W-1:1]};

    assign shift_next = shl_q ? {a_q[W-2:0], 1'b0} : {1'b0, a_q[W-1:1]};
    assign shift_bit  = shl_q ? a_q[W-1] : a_q[0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        shl_d   = shl_q;
        acc_d   = acc_q;
        wr      = 1'b0;
        res     = '0;
        c_f     = 1'b0;
        v_f     = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.alu_op_in)
                        OpAdd: begin
                            wr  = 1'b1;
                            res = add_sum[W-1:0];
                            c_f = add_sum[W];
                            v_f = (bus.alu_A_in[W-1] == bus.alu_B_in[W-1]) &&
                                  (add_sum[W-1] != bus.alu_A_in[W-1]);
                        end
                        OpSub: begin
                            wr  = 1'b1;
                            res = sub_diff[W-1:0];
                            c_f = sub_diff[W];
                            v_f = (bus.alu_A_in[W-1] != bus.alu_B_in[W-1]) &&
                                  (sub_diff[W-1] != bus.alu_A_in[W-1]);
                        end
                        OpAnd: begin
                            wr  = 1'b1;
                            res = bus.alu_A_in & bus.alu_B_in;
                        end
                        OpOr: begin
                            wr  = 1'b1;
                            res = bus.alu_A_in | bus.alu_B_in;
                        end
                        OpXor: begin
                            wr  = 1'b1;
                            res = bus.alu_A_in ^ bus.alu_B_in;
                        end
                        OpShl, OpShr: begin
                            if (shamt == '0) begin
                                wr  = 1'b1;
                                res = bus.alu_A_in;
                            end else begin
                                a_d     = bus.alu_A_in;
                                cnt_d   = {1'b0, shamt};
                                shl_d   = (bus.alu_op_in == OpShl);
                                state_d = StShift;
                            end
                        end
                        default: begin
                            if (MUL_ENABLE) begin
                                a_d     = bus.alu_A_in;
                                acc_d   = {{W{1'b0}}, bus.alu_B_in};
                                cnt_d   = CNT_W'(W);
                                state_d = StMul;
                            end else begin
                                wr  = 1'b1;
                                res = '0;
                            end
                        end
                    endcase
                end
            end
            StShift: begin
                a_d   = shift_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    wr      = 1'b1;
                    res     = shift_next;
                    c_f     = shift_bit;
                    state_d = StIdle;
                end
            end
            StMul: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                // Final iteration and write-back share one edge.
                if (cnt_q == CNT_W'(1)) begin
                    wr      = 1'b1;
                    res     = acc_step[W-1:0];
                    c_f     = |acc_step[2*W-1:W];
                    v_f     = |acc_step[2*W-1:W];
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        out_d = out_q;
        z_d   = z_q;
        n_d   = n_q;
        c_d   = c_q;
        v_d   = v_q;
        if (wr) begin
            out_d = res;
            z_d   = (res == '0);
            n_d   = res[W-1];
            c_d   = c_f;
            v_d   = v_f;
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= StIdle;
            a_q     <= '0;
            cnt_q   <= '0;
            shl_q   <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            shl_q   <= shl_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            done_q  <= wr;
        end
    end

    assign bus.alu_ready_out = (state_q == StIdle);
    assign bus.alu_done_out  = done_q;
    assign bus.alu_out       = out_q;
    assign bus.alu_Z_out     = z_q;
    assign bus.alu_N_out     = n_q;
    assign bus.alu_C_out     = c_q;
    assign bus.alu_V_out     = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at DATA_WIDTH=16: expectations are queued on accept and
// checked (result, flags, latency, busy cycles) when done pulses.
module tb_alu_seq;
    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    alu_seq_if #(.DATA_WIDTH(16)) bus ();

    alu_seq #(
        .DATA_WIDTH(16),
        .MUL_ENABLE(1'b1)
    ) dut (
        .clock_in(clk),
        .reset_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] p;
        logic        c, v;
        int          k;
        e.lat = 1;
        e.acc_cyc = 0;
        e.res = '0;
        c = 1'b0;
        v = 1'b0;
        k = int'(b[3:0]);
        case (op)
            OpAdd: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (e.res[15] != a[15]);
            end
            OpSub: begin
                e.res = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (e.res[15] != a[15]);
            end
            OpAnd: e.res = a & b;
            OpOr:  e.res = a | b;
            OpXor: e.res = a ^ b;
            OpShl: begin
                e.res = a << k;
                c = (k != 0) ? a[16-k] : 1'b0;
                e.lat = k + 1;
            end
            OpShr: begin
                e.res = a >> k;
                c = (k != 0) ? a[k-1] : 1'b0;
                e.lat = k + 1;
            end
            default: begin
                p = a * b;
                e.res = p[15:0];
                c = (p[31:16] != 16'h0);
                v = c;
                e.lat = 17;
            end
        endcase
        e.flags = {e.res == 16'h0, e.res[15], c, v};
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            busy_cnt = 0;
        end else begin
            if (!bus.alu_ready_out) busy_cnt++;
            if (bus.alu_done_out) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", 32'(bus.alu_done_out), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sb_out", 32'(bus.alu_out), 32'(mon_e.res));
                    check_eq("sb_flags", 32'({bus.alu_Z_out, bus.alu_N_out, bus.alu_C_out,
                                              bus.alu_V_out}), 32'(mon_e.flags));
                    check_eq("sb_latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                    check_eq("sb_busy", 32'(busy_cnt), 32'(mon_e.lat - 1));
                    busy_cnt = 0;
                end
            end
        end
    end

    // Drives a request now and returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        bus.alu_op_in = op;
        bus.alu_A_in = a;
        bus.alu_B_in = b;
        bus.alu_valid_in = 1'b1;
        while (!bus.alu_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check_eq("accept_timeout", 32'(bus.alu_ready_out), 32'd1);
            bus.alu_valid_in = 1'b0;
        end else begin
            sb.push_back(model(op, a, b));
            sb[sb.size()-1].acc_cyc = cyc;
            @(posedge clk);
            #1 bus.alu_valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic issue_wait(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        issue(op, a, b);
        drain();
    endtask

    task automatic check_outs(input string tag, input logic [15:0] r, input logic [3:0] f);
        check_eq(tag, 32'(bus.alu_out), 32'(r));
        check_eq(tag, 32'({bus.alu_Z_out, bus.alu_N_out, bus.alu_C_out, bus.alu_V_out}),
                 32'(f));
    endtask

    initial begin
        logic [15:0] held;
        int          n;
        bus.alu_valid_in = 1'b0;
        bus.alu_op_in = OpAdd;
        bus.alu_A_in = '0;
        bus.alu_B_in = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(bus.alu_ready_out), 32'd1);
        check_eq("rst_done", 32'(bus.alu_done_out), 32'd0);
        check_outs("rst_outs", 16'h0000, 4'b1000);
        rst = 1'b0;

        issue_wait(OpAdd, 16'h7FFF, 16'h0001);
        check_outs("add_ovf", 16'h8000, 4'b0101);
        issue_wait(OpAdd, 16'hFFFF, 16'h0001);
        check_outs("add_carry", 16'h0000, 4'b1010);
        issue_wait(OpSub, 16'h0005, 16'h0005);
        check_outs("sub_zero", 16'h0000, 4'b1000);
        issue_wait(OpSub, 16'h0003, 16'h0005);
        check_outs("sub_borrow", 16'hFFFE, 4'b0110);
        issue_wait(OpSub, 16'h8000, 16'h0001);
        check_outs("sub_ovf", 16'h7FFF, 4'b0001);
        issue_wait(OpAnd, 16'hF0F0, 16'h0FF0);
        issue_wait(OpOr, 16'hF000, 16'h000F);

        issue(OpShl, 16'h8001, 16'h0001);
        @(negedge clk);
        check_eq("shl_busy", 32'(bus.alu_ready_out), 32'd0);
        drain();
        check_outs("shl1", 16'h0002, 4'b0010);
        issue_wait(OpShr, 16'h0001, 16'h0004);
        check_outs("shr4", 16'h0000, 4'b1000);
        issue_wait(OpShl, 16'h1234, 16'h0010);
        check_outs("shl0", 16'h1234, 4'b0000);
        issue_wait(OpShr, 16'h8000, 16'h000F);

        // MUL with an ignored request pulsed while busy.
        issue(OpMul, 16'h0012, 16'h0034);
        held = bus.alu_out;
        repeat (3) @(negedge clk);
        bus.alu_op_in = OpAdd;
        bus.alu_A_in = 16'h1111;
        bus.alu_B_in = 16'h2222;
        bus.alu_valid_in = 1'b1;
        @(negedge clk);
        bus.alu_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mul_hold", 32'(bus.alu_out), 32'(held));
        end
        drain();
        check_outs("mul_small", 16'h03A8, 4'b0000);
        issue_wait(OpMul, 16'h0100, 16'h0100);
        check_outs("mul_ovf", 16'h0000, 4'b1011);

        // Back-to-back accept in the MUL done cycle.
        issue(OpMul, 16'h00FF, 16'h0101);
        n = 0;
        while (!bus.alu_done_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_done_seen", 32'(bus.alu_done_out), 32'd1);
        issue_wait(OpXor, 16'hF0F0, 16'hFFFF);
        check_outs("b2b_xor", 16'h0F0F, 4'b0000);

        // Asynchronous reset five cycles into a MUL.
        issue(OpMul, 16'h0012, 16'h0034);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(bus.alu_ready_out), 32'd1);
        check_eq("mid_rst_done", 32'(bus.alu_done_out), 32'd0);
        check_outs("mid_rst_outs", 16'h0000, 4'b1000);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_done_after_rst", 32'(bus.alu_done_out), 32'd0);
        end
        issue_wait(OpAdd, 16'h0002, 16'h0003);
        check_outs("add_after_rst", 16'h0005, 4'b0000);

        for (int i = 0; i < 12; i++) begin
            issue_wait(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        end

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
